crypt_session_ctrl: RTL
=======================

Name: crypt_session_ctrl

Overview:
Sequencing controller for the serial XOR-encryption datapath: key deserializer, message deserializer, xor encrypt stage and ciphertext serializer. It turns a host start command plus a serial bit-valid strobe into the per-deserializer load flags. It then launches encryption, waits for the serializer to drain and reports session status. It sits between the chip pins and the datapath, replacing direct pin-driven load flags.

Parameters:
MSG_SIZE, 128, message/ciphertext length in bits
KEY_SIZE, 8, key length in bits
TIMEOUT, 1023, max cycles waiting on encrypt or transmit completion before error

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  global enable; when low, all state and counters hold
iStart  input  1  start session (sampled in IDLE only)
iKey_reuse  input  1  sampled with iStart; skip key load if a key is held
iAbort  input  1  return to IDLE from any state next cycle
iBit_valid  input  1  host presents a valid serial bit this cycle
iEnc_done  input  1  level, encrypt stage reports ciphertext ready
iTx_active  input  1  serializer data flag (high while shifting out)
oKey_flag  output  1  load flag to key deserializer
oMsg_flag  output  1  load flag to message deserializer
oEnc_go  output  1  one-cycle pulse starting encryption
oTx_go  output  1  one-cycle pulse starting serializer
oBusy  output  1  high in any state except IDLE
oDone  output  1  one-cycle pulse on successful session end
oError  output  1  sticky timeout flag, cleared by next accepted iStart
oKey_valid  output  1  a complete key is held

Behaviour:
- Reset: state IDLE; all outputs 0; bit counter, timeout counter and key_valid cleared.
- ena low: state, counters and sticky flags hold; pulse outputs forced 0; oKey_flag/oMsg_flag forced 0.
- States: IDLE, LOAD_KEY, LOAD_MSG, ENC, WAIT_ENC, TX, WAIT_TX, DONE.
- IDLE: on iStart=1, clear oError and bit counter. If iKey_reuse=1 and oKey_valid=1, go to LOAD_MSG; otherwise clear key_valid and go to LOAD_KEY.
- LOAD_KEY: oKey_flag = iBit_valid, combinational and same cycle. The counter increments per valid bit. On the valid bit bringing the count to KEY_SIZE, set key_valid, clear the counter and go to LOAD_MSG.
- LOAD_MSG: identical, using oMsg_flag and MSG_SIZE; go to ENC on the last bit.
- Gaps in iBit_valid are allowed in either load state; the counter holds across them.
- ENC: oEnc_go=1 for exactly one cycle; clear the timeout counter; go to WAIT_ENC.
- WAIT_ENC: on iEnc_done=1, go to TX. Otherwise increment the timeout counter. When it reaches TIMEOUT, set oError and go to IDLE.
- TX: oTx_go=1 for one cycle; clear the timeout counter; go to WAIT_TX.
- WAIT_TX: first wait for iTx_active to rise (timeout as in WAIT_ENC), then for it to fall. The fall must be seen within MSG_SIZE+TIMEOUT cycles of the rise, else error. On the fall, go to DONE.
- DONE: oDone=1 for one cycle; go to IDLE. key_valid is retained.
- iAbort: highest priority in every non-IDLE state. Next state is IDLE; flags deassert that cycle; counters clear; key_valid clears only if the abort came in LOAD_KEY; oError unchanged.
- iStart outside IDLE is ignored. iStart and iAbort together in IDLE: iAbort wins, stay IDLE.
- Counter widths: $clog2(MSG_SIZE)+1 for bits; $clog2(TIMEOUT+MSG_SIZE)+1 for timeout; no wrap possible.
- Reset asserted mid-session: immediate return to reset values, including key_valid=0.

Decomposition:
- crypt_pkg: state enum, default MSG_SIZE/KEY_SIZE/TIMEOUT constants, counter width functions.
- Sub-module: phase_counter — loadable up-counter with enable, synchronous clear and terminal-count compare. Instanced twice: bit counter and timeout counter.

Test Plan:
- Full session: iStart, 8 valid bits then 128 valid bits, iEnc_done 3 cycles after oEnc_go, iTx_active high 128 cycles -> oKey_flag high exactly 8 cycles, oMsg_flag exactly 128, single oEnc_go/oTx_go/oDone pulses, oKey_valid=1 at end.
- Key reuse: second session with iKey_reuse=1 -> no oKey_flag, LOAD_MSG entered the cycle after iStart. Repeat with iKey_reuse=1 after reset -> key is loaded.
- Gapped bits: iBit_valid toggling 1,0,0,1 during loads -> flags mirror iBit_valid; transition only after the 8th/128th valid bit.
- Encrypt timeout: iEnc_done held 0 -> oError=1 after 1023 WAIT_ENC cycles, IDLE, no oTx_go. Next iStart clears oError.
- Abort in LOAD_MSG after 50 bits -> oBusy=0 next cycle, oMsg_flag=0, oKey_valid stays 1. A new session restarts the message count from 0.
- Async reset pulsed in WAIT_TX -> all outputs 0 immediately, oKey_valid=0. ena=0 during LOAD_KEY for 10 cycles -> counter and flags frozen, resumes correctly.

Source files
------------

// File: rtl/crypt_pkg.sv
// rtl/crypt_pkg.sv - shared state type, default sizes and counter width helpers
package crypt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_KEY = 3'd1,
    ST_LOAD_MSG = 3'd2,
    ST_ENC      = 3'd3,
    ST_WAIT_ENC = 3'd4,
    ST_TX       = 3'd5,
    ST_WAIT_TX  = 3'd6,
    ST_DONE     = 3'd7
  } state_e;

  localparam int DEF_MSG_SIZE = 128;
  localparam int DEF_KEY_SIZE = 8;
  localparam int DEF_TIMEOUT  = 1023;

  function automatic int bit_cnt_w(input int msg_size);
    return $clog2(msg_size) + 1;
  endfunction

  function automatic int tmo_cnt_w(input int timeout, input int msg_size);
    return $clog2(timeout + msg_size) + 1;
  endfunction

endpackage

// File: rtl/phase_counter.sv
// rtl/phase_counter.sv - loadable up-counter with enable, sync clear and terminal compare
module phase_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             inc_i,
  input  logic [WIDTH-1:0] term_val_i,
  output logic             term_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (ena_i) begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = (cnt_q == term_val_i);

endmodule

// File: rtl/crypt_session_ctrl.sv
// rtl/crypt_session_ctrl.sv - session sequencer for the serial XOR-encryption datapath
module crypt_session_ctrl
  import crypt_pkg::*;
#(
  parameter int MSG_SIZE = DEF_MSG_SIZE,
  parameter int KEY_SIZE = DEF_KEY_SIZE,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic iStart,
  input  logic iKey_reuse,
  input  logic iAbort,
  input  logic iBit_valid,
  input  logic iEnc_done,
  input  logic iTx_active,
  output logic oKey_flag,
  output logic oMsg_flag,
  output logic oEnc_go,
  output logic oTx_go,
  output logic oBusy,
  output logic oDone,
  output logic oError,
  output logic oKey_valid
);

  localparam int BW = bit_cnt_w(MSG_SIZE);
  localparam int TW = tmo_cnt_w(TIMEOUT, MSG_SIZE);

  // Terminal values are one below the limit: the compare fires on the cycle
  // whose event completes the count.
  localparam logic [BW-1:0] KEY_LAST   = BW'(KEY_SIZE - 1);
  localparam logic [BW-1:0] MSG_LAST   = BW'(MSG_SIZE - 1);
  localparam logic [TW-1:0] WAIT_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] DRAIN_LAST = TW'(MSG_SIZE + TIMEOUT - 1);

  state_e state_q, state_d;
  logic   key_valid_q, key_valid_d;
  logic   error_q, error_d;
  logic   tx_seen_q, tx_seen_d;

  logic          bit_clr, bit_inc, bit_last;
  logic [BW-1:0] bit_term;
  logic          tmo_clr, tmo_load, tmo_inc, tmo_last;
  logic [TW-1:0] tmo_term;

  phase_counter #(.WIDTH(BW)) u_bit_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena_i      (ena),
    .clr_i      (bit_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .inc_i      (bit_inc),
    .term_val_i (bit_term),
    .term_o     (bit_last)
  );

  phase_counter #(.WIDTH(TW)) u_tmo_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena_i      (ena),
    .clr_i      (tmo_clr),
    .load_i     (tmo_load),
    .load_val_i ('0),
    .inc_i      (tmo_inc),
    .term_val_i (tmo_term),
    .term_o     (tmo_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      key_valid_q <= 1'b0;
      error_q     <= 1'b0;
      tx_seen_q   <= 1'b0;
    end else if (ena) begin
      state_q     <= state_d;
      key_valid_q <= key_valid_d;
      error_q     <= error_d;
      tx_seen_q   <= tx_seen_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    key_valid_d = key_valid_q;
    error_d     = error_q;
    tx_seen_d   = tx_seen_q;
    bit_clr     = 1'b0;
    bit_inc     = 1'b0;
    bit_term    = KEY_LAST;
    tmo_clr     = 1'b0;
    tmo_load    = 1'b0;
    tmo_inc     = 1'b0;
    tmo_term    = WAIT_LAST;
    oKey_flag   = 1'b0;
    oMsg_flag   = 1'b0;
    oEnc_go     = 1'b0;
    oTx_go      = 1'b0;
    oDone       = 1'b0;

    if ((state_q != ST_IDLE) && iAbort) begin
      state_d   = ST_IDLE;
      bit_clr   = 1'b1;
      tmo_clr   = 1'b1;
      tx_seen_d = 1'b0;
      if (state_q == ST_LOAD_KEY) begin
        key_valid_d = 1'b0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (iStart && !iAbort) begin
            error_d = 1'b0;
            bit_clr = 1'b1;
            if (iKey_reuse && key_valid_q) begin
              state_d = ST_LOAD_MSG;
            end else begin
              key_valid_d = 1'b0;
              state_d     = ST_LOAD_KEY;
            end
          end
        end
        ST_LOAD_KEY: begin
          oKey_flag = iBit_valid;
          bit_inc   = iBit_valid;
          bit_term  = KEY_LAST;
          if (iBit_valid && bit_last) begin
            key_valid_d = 1'b1;
            bit_clr     = 1'b1;
            state_d     = ST_LOAD_MSG;
          end
        end
        ST_LOAD_MSG: begin
          oMsg_flag = iBit_valid;
          bit_inc   = iBit_valid;
          bit_term  = MSG_LAST;
          if (iBit_valid && bit_last) begin
            bit_clr = 1'b1;
            state_d = ST_ENC;
          end
        end
        ST_ENC: begin
          oEnc_go = 1'b1;
          tmo_clr = 1'b1;
          state_d = ST_WAIT_ENC;
        end
        ST_WAIT_ENC: begin
          if (iEnc_done) begin
            state_d = ST_TX;
          end else if (tmo_last) begin
            error_d = 1'b1;
            tmo_clr = 1'b1;
            state_d = ST_IDLE;
          end else begin
            tmo_inc = 1'b1;
          end
        end
        ST_TX: begin
          oTx_go    = 1'b1;
          tmo_clr   = 1'b1;
          tx_seen_d = 1'b0;
          state_d   = ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          // Two phases: wait for the serializer to start, then for it to drain.
          if (!tx_seen_q) begin
            tmo_term = WAIT_LAST;
            if (iTx_active) begin
              tx_seen_d = 1'b1;
              tmo_load  = 1'b1;
            end else if (tmo_last) begin
              error_d = 1'b1;
              tmo_clr = 1'b1;
              state_d = ST_IDLE;
            end else begin
              tmo_inc = 1'b1;
            end
          end else begin
            tmo_term = DRAIN_LAST;
            if (!iTx_active) begin
              tx_seen_d = 1'b0;
              tmo_clr   = 1'b1;
              state_d   = ST_DONE;
            end else if (tmo_last) begin
              error_d   = 1'b1;
              tx_seen_d = 1'b0;
              tmo_clr   = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              tmo_inc = 1'b1;
            end
          end
        end
        ST_DONE: begin
          oDone   = 1'b1;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    if (!ena) begin
      oKey_flag = 1'b0;
      oMsg_flag = 1'b0;
      oEnc_go   = 1'b0;
      oTx_go    = 1'b0;
      oDone     = 1'b0;
    end
  end

  assign oBusy      = (state_q != ST_IDLE);
  assign oError     = error_q;
  assign oKey_valid = key_valid_q;

endmodule
